// File: rtl/if_stage_if.sv
// Bundle of the fetch stage's control, ROM and IF/ID signals.
// The control/ROM side uses "master"; the fetch stage itself uses "slave".
interface if_stage_if;
  logic [1:0]  stall;
  logic        branch_flag;
  logic [31:0] branch_target;
  logic        flush;
  logic [31:0] new_pc;
  logic [31:0] rom_inst;
  logic        rom_ce;
  logic [31:0] pc;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_valid;

  modport master (
    output stall, branch_flag, branch_target, flush, new_pc, rom_inst,
    input  rom_ce, pc, id_pc, id_inst, id_valid
  );

  modport slave (
    input  stall, branch_flag, branch_target, flush, new_pc, rom_inst,
    output rom_ce, pc, id_pc, id_inst, id_valid
  );
endinterface

// File: rtl/if_stage.sv
// OpenMIPS instruction-fetch stage: program counter, ROM enable and IF/ID register.
// Redirect priority: ROM-disabled restart, flush, stall hold, delayed branch, sequential.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic      clk,
  input  logic      rst,
  if_stage_if.slave bus
);

  logic        rom_ce_q,   rom_ce_d;
  logic [31:0] pc_q,       pc_d;
  logic [31:0] id_pc_q,    id_pc_d;
  logic [31:0] id_inst_q,  id_inst_d;
  logic        id_valid_q, id_valid_d;

  // The ROM is enabled from the first edge after reset release onwards.
  always_comb begin
    rom_ce_d = 1'b1;
  end

  // A branch seen while any stall is active is intentionally dropped.
  always_comb begin
    pc_d = pc_q;
    if (!rom_ce_q) begin
      pc_d = RESET_PC;
    end else if (bus.flush) begin
      pc_d = bus.new_pc & ~32'h3;
    end else if (bus.stall != 2'b00) begin
      pc_d = pc_q;
    end else if (bus.branch_flag) begin
      pc_d = bus.branch_target & ~32'h3;
    end else begin
      pc_d = pc_q + 32'd4;
    end
  end

  always_comb begin
    id_pc_d    = id_pc_q;
    id_inst_d  = id_inst_q;
    id_valid_d = id_valid_q;
    if (bus.flush) begin
      id_pc_d    = 32'h0;
      id_inst_d  = NOP_INST;
      id_valid_d = 1'b0;
    end else if (bus.stall[1]) begin
      id_pc_d    = id_pc_q;
      id_inst_d  = id_inst_q;
      id_valid_d = id_valid_q;
    end else if (bus.stall[0]) begin
      id_pc_d    = 32'h0;
      id_inst_d  = NOP_INST;
      id_valid_d = 1'b0;
    end else begin
      id_pc_d    = pc_q;
      id_inst_d  = rom_ce_q ? bus.rom_inst : NOP_INST;
      id_valid_d = rom_ce_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rom_ce_q   <= 1'b0;
      pc_q       <= RESET_PC;
      id_pc_q    <= 32'h0;
      id_inst_q  <= NOP_INST;
      id_valid_q <= 1'b0;
    end else begin
      rom_ce_q   <= rom_ce_d;
      pc_q       <= pc_d;
      id_pc_q    <= id_pc_d;
      id_inst_q  <= id_inst_d;
      id_valid_q <= id_valid_d;
    end
  end

  assign bus.rom_ce   = rom_ce_q;
  assign bus.pc       = pc_q;
  assign bus.id_pc    = id_pc_q;
  assign bus.id_inst  = id_inst_q;
  assign bus.id_valid = id_valid_q;

endmodule
